sram_access_arbiter: RTL and testbench

//  Shares the single external SRAM port among NUM_REQ bus masters: block fetch (SRAM->DP-RAM),
//  DP-RAM->SRAM write-back, and the upsampling/colour-space stage. Burst-locked round-robin

---
 rtl/sram_access_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_access_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Burst-locked round-robin arbiter sharing one SRAM port among NUM_REQ masters.
// Read data is returned to its owner through a tag pipe matching the SRAM latency.
module sram_access_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 64
) (
    input  logic                      Clock_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic [DATA_W-1:0]         SRAM_read_data,
    output logic [ADDR_W-1:0]         SRAM_address,
    output logic [DATA_W-1:0]         SRAM_write_data,
    output logic                      SRAM_we
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [OW-1:0] REQ_LAST = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_GRANT,
        S_ARB_GAP
    } arb_state_e;

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [CW-1:0]      burst_ctr_q, burst_ctr_d;

    logic              rd_vld_q [READ_LATENCY];
    logic              rd_vld_d [READ_LATENCY];
    logic [OW-1:0]     rd_tag_q [READ_LATENCY];
    logic [OW-1:0]     rd_tag_d [READ_LATENCY];

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     cand;
    logic              access;
    logic              own_we;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Search starts one past the previous winner, so a preempted owner goes last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == REQ_LAST) ? '0 : cand + OW'(1);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign access = gnt_q[owner_q] & req[owner_q];
    assign own_we = req_we[owner_q];

    assign SRAM_address    = access ? addr_arr[owner_q] : '0;
    assign SRAM_write_data = access ? wdata_arr[owner_q] : '0;
    assign SRAM_we         = access & own_we;

    assign gnt     = gnt_q;
    assign rd_data = SRAM_read_data;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_ctr_d = burst_ctr_q;
        unique case (state_q)
            S_ARB_IDLE, S_ARB_GAP: begin
                gnt_d   = '0;
                state_d = S_ARB_IDLE;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    last_d          = pick_idx;
                    burst_ctr_d     = '0;
                    state_d         = S_ARB_GRANT;
                end
            end
            S_ARB_GRANT: begin
                if (!req[owner_q] || burst_ctr_q == BURST_LAST) begin
                    gnt_d   = '0;
                    state_d = S_ARB_GAP;
                end else begin
                    burst_ctr_d = burst_ctr_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_vld_d[0] = access & ~own_we;
        rd_tag_d[0] = owner_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_tag_d[i] = rd_tag_q[i-1];
        end
    end

    always_comb begin
        rd_valid = '0;
        rd_valid[rd_tag_q[READ_LATENCY-1]] = rd_vld_q[READ_LATENCY-1];
    end

    always_ff @(posedge Clock_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_ARB_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            last_q      <= REQ_LAST;
            burst_ctr_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= 1'b0;
                rd_tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_ctr_q <= burst_ctr_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_d[i];
                rd_tag_q[i] <= rd_tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed bursts, a queue-based reference
// model checked every cycle, and literal expectations at key cycles.
module tb_sram_access_arbiter;

    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int MB = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we, gnt, rd_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rd_data, sram_rdata, sram_wdata;
    logic [AW-1:0]   sram_addr;
    logic            sram_we;

    int n_pass  = 0;
    int n_total = 0;

    int            rem      [N];
    bit            by_cycle [N];
    logic [AW-1:0] cur_addr [N];

    always #5 clk = ~clk;

    sram_access_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .Clock_50(clk),
        .reset(rst),
        .req(req),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .gnt(gnt),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .SRAM_read_data(sram_rdata),
        .SRAM_address(sram_addr),
        .SRAM_write_data(sram_wdata),
        .SRAM_we(sram_we)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic put_addr(input int i);
        req_addr[i*AW +: AW]  = cur_addr[i];
        req_wdata[i*DW +: DW] = cur_addr[i][DW-1:0] ^ 16'hA5A5;
    endtask

    task automatic start_burst(input int i, input logic we,
                               input logic [AW-1:0] a, input int len,
                               input bit cyc_mode);
        rem[i]      = len;
        by_cycle[i] = cyc_mode;
        cur_addr[i] = a;
        req_we[i]   = we;
        req[i]      = 1'b1;
        put_addr(i);
    endtask

    // One clock: a master advances its address only on a performed access.
    task automatic step();
        logic [N-1:0] perf;
        @(negedge clk);
        perf = gnt & req;
        @(posedge clk);
        #1;
        sram_rdata = DW'($urandom);
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (perf[i]) begin
                    cur_addr[i] = cur_addr[i] + 1'b1;
                    put_addr(i);
                end
                if (by_cycle[i] || perf[i]) rem[i]--;
                if (rem[i] <= 0) req[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((req != 0 || gnt != 0) && k < budget) begin
            step();
            k++;
        end
        chk(name, {req, gnt}, 0);
    endtask

    task automatic drop_all();
        for (int i = 0; i < N; i++) rem[i] = 0;
        req = '0;
    endtask

    // Reference: a grant is either held or not; reads return after RL cycles.
    initial begin : model
        int            due_q [$];
        int            own_q [$];
        bit            m_gr, acc;
        int            m_own, m_last, m_cnt, cyc, cidx;
        logic [N-1:0]  e_gnt, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we;
        m_gr   = 1'b0;
        m_own  = 0;
        m_last = N - 1;
        m_cnt  = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            e_gnt  = '0;
            e_rv   = '0;
            e_addr = '0;
            e_wd   = '0;
            e_we   = 1'b0;
            acc    = 1'b0;
            if (rst) begin
                m_gr   = 1'b0;
                m_last = N - 1;
                m_cnt  = 0;
                due_q.delete();
                own_q.delete();
            end else begin
                if (m_gr) begin
                    e_gnt[m_own] = 1'b1;
                    acc = req[m_own];
                end
                if (acc) begin
                    e_addr = req_addr[m_own*AW +: AW];
                    e_wd   = req_wdata[m_own*DW +: DW];
                    e_we   = req_we[m_own];
                end
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    e_rv[own_q[0]] = 1'b1;
                    void'(due_q.pop_front());
                    void'(own_q.pop_front());
                end
            end
            chk("m_gnt", gnt, e_gnt);
            chk("m_addr", sram_addr, e_addr);
            chk("m_wdata", sram_wdata, e_wd);
            chk("m_we", sram_we, e_we);
            chk("m_rd_valid", rd_valid, e_rv);
            chk("m_rd_data", rd_data, sram_rdata);
            if (!rst) begin
                if (acc && !req_we[m_own]) begin
                    due_q.push_back(cyc + RL);
                    own_q.push_back(m_own);
                end
                if (m_gr) begin
                    if (!acc || m_cnt == MB - 1) m_gr = 1'b0;
                    else m_cnt++;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        cidx = (m_last + k) % N;
                        if (!m_gr && req[cidx]) begin
                            m_gr   = 1'b1;
                            m_own  = cidx;
                            m_last = cidx;
                            m_cnt  = 0;
                        end
                    end
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n_we, n_rv;
        rst        = 1'b1;
        req        = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        sram_rdata = '0;
        for (int i = 0; i < N; i++) begin
            rem[i]      = 0;
            by_cycle[i] = 1'b0;
            cur_addr[i] = '0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // single 4-beat read
        start_burst(0, 1'b0, 18'h100, 4, 1'b0);
        step();
        chk("t2_gnt", gnt, 3'b001);
        chk("t2_addr0", sram_addr, 18'h100);
        step();
        step();
        chk("t2_rv_first", rd_valid, 3'b001);
        chk("t2_addr2", sram_addr, 18'h102);
        step();
        step();
        chk("t2_rel_gnt", gnt, 3'b001);
        chk("t2_rel_addr", sram_addr, 0);
        chk("t2_rel_rv", rd_valid, 3'b001);
        step();
        chk("t2_gap_gnt", gnt, 0);
        chk("t2_last_rv", rd_valid, 3'b001);
        step();
        chk("t2_done_rv", rd_valid, 0);
        wait_idle("t2_idle", 20);

        // simultaneous requests from reset, then again
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_burst(0, 1'b0, 18'h300, 3, 1'b0);
        start_burst(1, 1'b0, 18'h400, 3, 1'b0);
        step();
        chk("t3_first", gnt, 3'b001);
        chk("t3_addr", sram_addr, 18'h300);
        repeat (4) step();
        chk("t3_gap", gnt, 0);
        step();
        chk("t3_second", gnt, 3'b010);
        chk("t3_addr1", sram_addr, 18'h400);
        repeat (4) step();
        chk("t3_gap2", gnt, 0);
        start_burst(0, 1'b0, 18'h310, 2, 1'b0);
        start_burst(1, 1'b0, 18'h410, 2, 1'b0);
        step();
        chk("t3_again", gnt, 3'b001);
        wait_idle("t3_idle", 40);

        // fairness cap: long write burst with a pending reader
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_burst(1, 1'b1, 18'h500, 100, 1'b1);
        start_burst(2, 1'b0, 18'h600, 5, 1'b0);
        n_we = 0;
        for (int i = 0; i < 65; i++) begin
            step();
            if (sram_we) n_we++;
        end
        chk("t4_we_count", n_we, 64);
        chk("t4_gap", gnt, 0);
        step();
        chk("t4_gnt2", gnt, 3'b100);
        repeat (7) step();
        chk("t4_regrant1", gnt, 3'b010);
        wait_idle("t4_idle", 200);

        // reads drain through the gap into the next grant
        start_burst(0, 1'b0, 18'h200, 2, 1'b0);
        repeat (3) step();
        chk("t5_rv_a", rd_valid, 3'b001);
        start_burst(1, 1'b1, 18'h700, 3, 1'b0);
        step();
        chk("t5_gap_gnt", gnt, 0);
        chk("t5_rv_b", rd_valid, 3'b001);
        step();
        chk("t5_gnt1", gnt, 3'b010);
        chk("t5_rv_end", rd_valid, 0);
        n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rd_valid[1]) n_rv++;
        end
        chk("t5_no_rv1", n_rv, 0);
        wait_idle("t5_idle", 20);

        // early release mid-burst
        start_burst(2, 1'b1, 18'h800, 10, 1'b0);
        start_burst(0, 1'b0, 18'hA00, 3, 1'b0);
        repeat (11) step();
        chk("t6_rel_gnt", gnt, 3'b100);
        chk("t6_rel_we", sram_we, 0);
        chk("t6_rel_addr", sram_addr, 0);
        step();
        chk("t6_gap", gnt, 0);
        step();
        chk("t6_next", gnt, 3'b001);
        chk("t6_next_addr", sram_addr, 18'hA00);
        wait_idle("t6_idle", 20);

        // reset in the middle of a read burst
        start_burst(0, 1'b0, 18'h900, 20, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        drop_all();
        #1;
        chk("t1_gnt", gnt, 0);
        chk("t1_we", sram_we, 0);
        chk("t1_rv", rd_valid, 0);
        repeat (2) step();
        rst = 1'b0;
        n_rv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd_valid != 0) n_rv++;
        end
        chk("t1_no_returns", n_rv, 0);
        chk("t1_idle_gnt", gnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
